// File: rtl/levit_cls_head.sv
// LeViT classification head: per-class dot-product accumulation over the pooled feature stream, then a sequential argmax.
// Optional: define CLS_BIAS_EN to add a packed per-class bias (i_bias) folded into the final accumulation.
module levit_cls_head #(
    parameter int DATA_W  = 16,
    parameter int W_W     = 8,
    parameter int N_FEAT  = 16,
    parameter int N_CLASS = 10,
    parameter int ACC_W   = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          i_valid,
    input  logic signed [DATA_W-1:0]      i_feat,
    input  logic [N_CLASS*W_W-1:0]        i_w,
`ifdef CLS_BIAS_EN
    input  logic [N_CLASS*ACC_W-1:0]      i_bias,
`endif
    output logic                          o_ready,
    output logic [$clog2(N_CLASS)-1:0]    o_class,
    output logic signed [ACC_W-1:0]       o_score,
    output logic                          end_cls
);

    localparam int CNT_W  = $clog2(N_FEAT + 1);
    localparam int CLS_W  = $clog2(N_CLASS);
    localparam int PROD_W = DATA_W + W_W;

    if (ACC_W < DATA_W + W_W + $clog2(N_FEAT)) begin : g_acc_w_check
        $error("levit_cls_head: ACC_W too narrow for DATA_W+W_W+clog2(N_FEAT)");
    end
    if (N_CLASS < 2) begin : g_n_class_check
        $error("levit_cls_head: N_CLASS must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ACC, ARGMAX, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         count_reg;
    logic [CLS_W-1:0]         scan_reg;
    logic [CLS_W-1:0]         best_idx_reg;
    logic signed [ACC_W-1:0]  best_reg;
    logic signed [ACC_W-1:0]  acc_val [N_CLASS];

    logic accept;
    logic last_feat;
    logic scan_last;
    logic in_idle;
    logic in_argmax;
    logic in_done;

    assign accept    = en & i_valid & o_ready;
    assign last_feat = accept && (count_reg == CNT_W'(N_FEAT - 1));
    assign scan_last = (scan_reg == CLS_W'(N_CLASS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (last_feat) begin
                    state_next = ARGMAX;
                end else if (accept) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (last_feat) begin
                    state_next = ARGMAX;
                end
            end
            ARGMAX: begin
                if (scan_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs and controls
    always_comb begin
        in_idle   = (state_reg == IDLE);
        in_argmax = (state_reg == ARGMAX);
        in_done   = (state_reg == DONE);
        o_ready   = (state_reg == IDLE) || (state_reg == ACC);
    end

    // One multiply-accumulate lane per class
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_cls
        logic signed [W_W-1:0]    w_k;
        logic signed [PROD_W-1:0] prod;
        logic signed [ACC_W-1:0]  prod_ext;
        logic signed [ACC_W-1:0]  bias_k;
        logic signed [ACC_W-1:0]  acc_base;
        logic signed [ACC_W-1:0]  acc_reg, acc_next;

        assign w_k      = i_w[gi*W_W +: W_W];
        assign prod     = i_feat * w_k;
        assign prod_ext = ACC_W'(prod);
`ifdef CLS_BIAS_EN
        assign bias_k   = last_feat ? i_bias[gi*ACC_W +: ACC_W] : '0;
`else
        assign bias_k   = '0;
`endif
        assign acc_base = in_idle ? '0 : acc_reg;

        always_comb begin
            acc_next = acc_reg;
            if (in_done) begin
                acc_next = '0;
            end else if (accept) begin
                acc_next = acc_base + prod_ext + bias_k;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_reg <= '0;
            end else begin
                acc_reg <= acc_next;
            end
        end

        assign acc_val[gi] = acc_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (in_done) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Argmax scan: strict greater-than keeps the lowest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_reg     <= '0;
            best_reg     <= '0;
            best_idx_reg <= '0;
        end else begin
            if (last_feat) begin
                scan_reg <= '0;
            end else if (in_argmax) begin
                scan_reg <= scan_reg + CLS_W'(1);
            end
            if (in_argmax) begin
                if ((scan_reg == '0) || (acc_val[scan_reg] > best_reg)) begin
                    best_reg     <= acc_val[scan_reg];
                    best_idx_reg <= scan_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_class <= '0;
            o_score <= '0;
            end_cls <= 1'b0;
        end else begin
            end_cls <= in_done;
            if (in_done) begin
                o_class <= best_idx_reg;
                o_score <= best_reg;
            end
        end
    end

endmodule

// File: tb/tb_levit_cls_head.sv
// Scoreboard bench for levit_cls_head: the driver pushes reference results, a negedge monitor checks each end_cls.
// Builds with or without CLS_BIAS_EN; the reference model follows the same define.
module tb_levit_cls_head;

    localparam int DATA_W  = 16;
    localparam int W_W     = 8;
    localparam int N_FEAT  = 16;
    localparam int N_CLASS = 10;
    localparam int ACC_W   = 40;
    localparam int CLS_W   = $clog2(N_CLASS);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        en = 1'b0;
    logic                        i_valid = 1'b0;
    logic signed [DATA_W-1:0]    i_feat = '0;
    logic [N_CLASS*W_W-1:0]      i_w = '0;
`ifdef CLS_BIAS_EN
    logic [N_CLASS*ACC_W-1:0]    i_bias = '0;
`endif
    logic                        o_ready;
    logic [CLS_W-1:0]            o_class;
    logic signed [ACC_W-1:0]     o_score;
    logic                        end_cls;

    always #5 clk = ~clk;

    levit_cls_head #(
        .DATA_W(DATA_W), .W_W(W_W), .N_FEAT(N_FEAT), .N_CLASS(N_CLASS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .i_valid(i_valid),
        .i_feat(i_feat),
        .i_w(i_w),
`ifdef CLS_BIAS_EN
        .i_bias(i_bias),
`endif
        .o_ready(o_ready),
        .o_class(o_class),
        .o_score(o_score),
        .end_cls(end_cls)
    );

    typedef struct {
        int     cls;
        longint score;
        int     t;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     cyc = 0;
    int     checks = 0;
    int     failures = 0;
    int     ready_err = 0;
    int     n_tx = 0;

    int     feat_a [N_FEAT];
    int     w_a    [N_FEAT][N_CLASS];
    longint bias_a [N_CLASS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference: plain dot products (plus bias), then first maximum wins
    function automatic void model(output int cls, output longint score);
        longint s [N_CLASS];
        for (int k = 0; k < N_CLASS; k++) begin
`ifdef CLS_BIAS_EN
            s[k] = bias_a[k];
`else
            s[k] = 0;
`endif
            for (int n = 0; n < N_FEAT; n++) begin
                s[k] += longint'(feat_a[n]) * longint'(w_a[n][k]);
            end
        end
        cls   = 0;
        score = s[0];
        for (int k = 1; k < N_CLASS; k++) begin
            if (s[k] > score) begin
                cls   = k;
                score = s[k];
            end
        end
    endfunction

    task automatic fill(input int mode);
        logic signed [DATA_W-1:0] r_f;
        logic signed [W_W-1:0]    r_w;
        for (int n = 0; n < N_FEAT; n++) begin
            for (int k = 0; k < N_CLASS; k++) begin
                case (mode)
                    0: begin feat_a[n] = 1;  w_a[n][k] = k;       end
                    1: begin feat_a[n] = -3; w_a[n][k] = -(k + 1); end
                    2: begin feat_a[n] = -3; w_a[n][k] = k - 5;   end
                    3: begin feat_a[n] = 2;  w_a[n][k] = (k == 2 || k == 7) ? 4 : 0; end
                    default: begin
                        r_w = W_W'($urandom);
                        w_a[n][k] = r_w;
                    end
                endcase
            end
            if (mode > 3) begin
                r_f = DATA_W'($urandom);
                feat_a[n] = r_f;
            end
        end
        for (int k = 0; k < N_CLASS; k++) begin
            bias_a[k] = (mode > 3) ? longint'($urandom_range(0, 400000)) - 200000 : 0;
        end
    endtask

    task automatic drive_junk(input bit junk);
        en      = 1'b1;
        i_valid = junk;
        i_feat  = DATA_W'($urandom);
        for (int k = 0; k < N_CLASS; k++) i_w[k*W_W +: W_W] = W_W'($urandom);
    endtask

    task automatic present(input int n);
        en      = 1'b1;
        i_valid = 1'b1;
        i_feat  = DATA_W'(feat_a[n]);
        for (int k = 0; k < N_CLASS; k++) i_w[k*W_W +: W_W] = W_W'(w_a[n][k]);
`ifdef CLS_BIAS_EN
        for (int k = 0; k < N_CLASS; k++) i_bias[k*ACC_W +: ACC_W] = ACC_W'(bias_a[k]);
`endif
    endtask

    // Sends n_send features; the final one of a full run registers the expected result
    task automatic run_inf(input int n_send, input bit gaps, input bit junk);
        int     guard;
        int     g;
        int     cls;
        longint score;
        for (int n = 0; n < n_send; n++) begin
            if (gaps && n > 0 && (n == 8 || $urandom_range(0, 2) == 0)) begin
                g = (n == 8) ? 5 : $urandom_range(1, 5);
                for (int j = 0; j < g; j++) begin
                    @(negedge clk);
                    drive_junk(1'b1);
                    if ($urandom_range(0, 1) == 1) en = 1'b0;
                    else i_valid = 1'b0;
                end
            end
            @(negedge clk);
            guard = 0;
            while (!o_ready) begin
                drive_junk(junk);
                @(negedge clk);
                guard++;
                if (guard > 100) begin
                    failures++;
                    $display("FAIL ready_timeout: got o_ready=0 for %0d cycles required 1", guard);
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $fatal(1, "o_ready timeout");
                end
            end
            present(n);
            if (n == N_FEAT - 1) begin
                model(cls, score);
                exp_q.push_back('{cls, score, cyc + 1});
            end
        end
        @(negedge clk);
        drive_junk(junk && (n_send == N_FEAT));
    endtask

    // Monitor: o_ready must stay low through ARGMAX/DONE, end_cls must match the queued result
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && o_ready && cyc >= exp_q[0].t && cyc <= exp_q[0].t + N_CLASS)
                ready_err++;
            if (end_cls) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_end_cls: got end_cls=1 at cycle %0d required 0", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_tx++;
                    $display("tx %0d: class=%0d score=%0d cycle=%0d | expected class=%0d score=%0d cycle=%0d",
                             n_tx, o_class, o_score, cyc, mon_e.cls, mon_e.score, mon_e.t + N_CLASS + 1);
                    chk("o_class", longint'(o_class), longint'(mon_e.cls));
                    chk("o_score", longint'(o_score), mon_e.score);
                    chk("end_cls_cycle", longint'(cyc), longint'(mon_e.t + N_CLASS + 1));
                    chk("o_ready_high_while_busy", longint'(ready_err), 0);
                    ready_err = 0;
                end
            end
        end
    end

    initial begin
        int guard;
        for (int k = 0; k < N_CLASS; k++) bias_a[k] = 0;

        repeat (3) @(negedge clk);
        chk("reset_o_class", longint'(o_class), 0);
        chk("reset_o_score", longint'(o_score), 0);
        chk("reset_end_cls", longint'(end_cls), 0);
        chk("reset_o_ready", longint'(o_ready), 1);
        rst = 1'b0;

        fill(0); run_inf(N_FEAT, 1'b0, 1'b0);
`ifdef CLS_BIAS_EN
        fill(0); bias_a[0] = 1000; run_inf(N_FEAT, 1'b0, 1'b0);
`endif
        fill(1); run_inf(N_FEAT, 1'b0, 1'b1);
        fill(2); run_inf(N_FEAT, 1'b0, 1'b1);
        fill(3); run_inf(N_FEAT, 1'b0, 1'b0);
        fill(0); run_inf(N_FEAT, 1'b1, 1'b0);

        // Abort after 8 features, then replay the same data cleanly
        fill(4); run_inf(8, 1'b0, 1'b0);
        rst = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("midrst_o_class", longint'(o_class), 0);
        chk("midrst_o_score", longint'(o_score), 0);
        chk("midrst_end_cls", longint'(end_cls), 0);
        chk("midrst_o_ready", longint'(o_ready), 1);
        rst = 1'b0;
        run_inf(N_FEAT, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            fill(4);
            run_inf(N_FEAT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        en = 1'b0;
        i_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL missing_end_cls: got %0d results outstanding required 0", exp_q.size());
        end
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
